box_renderer: RTL

Pixel-stage compositor that sits directly downstream of `game_core` and upstream of the VGA output pins. On each `frame_tick` it snapshots box positions, hit counters and colour indices. For every pixel of the following frame it resolves which box, if any, covers the current raster position, then emits 2-bit-per-channel RGB. Sync and display-enable are delayed to match, and a box whose hit counter changed is briefly drawn white.

---
 rtl/box_renderer.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/box_renderer.sv
// Pixel compositor: snapshots box state on frame_tick, hit-tests each pixel and emits 2-bit RGB with
// sync/de delayed by 2 clk. Optional hit flash is built when BOX_RENDERER_HIT_FLASH_EN is defined.
module box_renderer #(
    parameter int N            = 4,
    parameter int BOX_W        = 48,
    parameter int BOX_H        = 32,
    parameter int FLASH_FRAMES = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_tick,
    input  logic [9:0]        hpos,
    input  logic [9:0]        vpos,
    input  logic              de_in,
    input  logic              hsync_in,
    input  logic              vsync_in,
    input  logic [10*N-1:0]   posx_flat,
    input  logic [9*N-1:0]    posy_flat,
    input  logic [8*N-1:0]    hits_flat,
    input  logic [3*N-1:0]    color_flat,
    output logic [1:0]        r,
    output logic [1:0]        g,
    output logic [1:0]        b,
    output logic              hsync_out,
    output logic              vsync_out,
    output logic              de_out
);

    localparam logic [10:0] BOX_W11 = 11'(BOX_W);
    localparam logic [10:0] BOX_H11 = 11'(BOX_H);

    // Shadow copy of game_core state, frozen for the whole frame
    logic [N-1:0][9:0] posx_q,  posx_d;
    logic [N-1:0][8:0] posy_q,  posy_d;
    logic [N-1:0][2:0] color_q, color_d;
    logic              snap_valid_q, snap_valid_d;

    // Stage 1 and stage 2 pipeline registers
    logic [N-1:0] inside_q, inside_d;
    logic         de1_q, de1_d;
    logic         hs1_q, hs1_d;
    logic         vs1_q, vs1_d;
    logic [5:0]   rgb_q, rgb_d;
    logic         de2_q, de2_d;
    logic         hs2_q, hs2_d;
    logic         vs2_q, vs2_d;

    logic [N-1:0] flashing;

    function automatic logic [5:0] palette(input logic [2:0] idx);
        logic [5:0] c;
        case (idx)
            3'd0:    c = 6'b110000;
            3'd1:    c = 6'b001100;
            3'd2:    c = 6'b000011;
            3'd3:    c = 6'b111100;
            3'd4:    c = 6'b110011;
            3'd5:    c = 6'b001111;
            3'd6:    c = 6'b101010;
            default: c = 6'b011001;
        endcase
        return c;
    endfunction

    // 11-bit compares so X+BOX_W / Y+BOX_H never wrap near the screen edge
    function automatic logic in_box(input logic [9:0] h, input logic [9:0] v,
                                    input logic [9:0] x, input logic [8:0] y);
        logic [10:0] h11, v11, x11, y11;
        h11 = {1'b0, h};
        v11 = {1'b0, v};
        x11 = {1'b0, x};
        y11 = {2'b00, y};
        return (h11 >= x11) && (h11 < x11 + BOX_W11) &&
               (v11 >= y11) && (v11 < y11 + BOX_H11);
    endfunction

    always_comb begin
        posx_d       = posx_q;
        posy_d       = posy_q;
        color_d      = color_q;
        snap_valid_d = snap_valid_q;
        if (frame_tick) begin
            posx_d       = posx_flat;
            posy_d       = posy_flat;
            color_d      = color_flat;
            snap_valid_d = 1'b1;
        end
    end

`ifdef BOX_RENDERER_HIT_FLASH_EN
    logic [N-1:0][7:0] hits_in;
    logic [N-1:0][7:0] prev_hits_q, prev_hits_d;
    logic [N-1:0][3:0] flash_q, flash_d;

    assign hits_in = hits_flat;

    always_comb begin
        prev_hits_d = prev_hits_q;
        flash_d     = flash_q;
        flashing    = '0;
        for (int i = 0; i < N; i++) begin
            flashing[i] = (flash_q[i] != 4'd0);
            if (frame_tick) begin
                // A new hit restarts the count even mid-flash
                if (hits_in[i] != prev_hits_q[i]) begin
                    flash_d[i] = 4'(FLASH_FRAMES);
                end else if (flash_q[i] != 4'd0) begin
                    flash_d[i] = flash_q[i] - 4'd1;
                end
                prev_hits_d[i] = hits_in[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_hits_q <= '0;
            flash_q     <= '0;
        end else begin
            prev_hits_q <= prev_hits_d;
            flash_q     <= flash_d;
        end
    end
`else
    logic unused_hits;
    assign unused_hits = ^hits_flat;
    assign flashing    = '0;
`endif

    always_comb begin
        inside_d = '0;
        for (int i = 0; i < N; i++) begin
            inside_d[i] = snap_valid_q && in_box(hpos, vpos, posx_q[i], posy_q[i]);
        end
        de1_d = de_in;
        hs1_d = hsync_in;
        vs1_d = vsync_in;
    end

    // Scan from the top index down so the lowest covering box is the last write
    always_comb begin
        rgb_d = 6'b000000;
        for (int i = N - 1; i >= 0; i--) begin
            if (inside_q[i]) begin
                rgb_d = flashing[i] ? 6'b111111 : palette(color_q[i]);
            end
        end
        if (!de1_q) begin
            rgb_d = 6'b000000;
        end
        de2_d = de1_q;
        hs2_d = hs1_q;
        vs2_d = vs1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            posx_q       <= '0;
            posy_q       <= '0;
            color_q      <= '0;
            snap_valid_q <= 1'b0;
            inside_q     <= '0;
            de1_q        <= 1'b0;
            hs1_q        <= 1'b1;
            vs1_q        <= 1'b1;
            rgb_q        <= 6'b000000;
            de2_q        <= 1'b0;
            hs2_q        <= 1'b1;
            vs2_q        <= 1'b1;
        end else begin
            posx_q       <= posx_d;
            posy_q       <= posy_d;
            color_q      <= color_d;
            snap_valid_q <= snap_valid_d;
            inside_q     <= inside_d;
            de1_q        <= de1_d;
            hs1_q        <= hs1_d;
            vs1_q        <= vs1_d;
            rgb_q        <= rgb_d;
            de2_q        <= de2_d;
            hs2_q        <= hs2_d;
            vs2_q        <= vs2_d;
        end
    end

    assign {r, g, b}  = rgb_q;
    assign hsync_out  = hs2_q;
    assign vsync_out  = vs2_q;
    assign de_out     = de2_q;

endmodule
